// File: rtl/seq_ram_pkg.sv
// Shared definitions for the sequencing RAM player: FSM state encoding and
// PLAY/RECORD opcode values.
package seq_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_REC  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic OP_PLAY = 1'b0;
  localparam logic OP_REC  = 1'b1;

endpackage

// File: rtl/seq_ram_player_if.sv
// Bus bundle for seq_ram_player: random-access port, command inputs,
// PLAY stream out, RECORD stream in and status flags.
interface seq_ram_player_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] q;
  logic              start;
  logic              op;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic              seq_valid;
  logic              seq_ready;
  logic [DATA_W-1:0] seq_data;
  logic              seq_last;
  logic              rec_valid;
  logic              rec_ready;
  logic [DATA_W-1:0] rec_data;
  logic              busy;
  logic              done;

  modport master (
    output ram_we, ram_addr, ram_data, start, op, len, abort,
           seq_ready, rec_valid, rec_data,
    input  q, seq_valid, seq_data, seq_last, rec_ready, busy, done
  );

  modport slave (
    input  ram_we, ram_addr, ram_data, start, op, len, abort,
           seq_ready, rec_valid, rec_data,
    output q, seq_valid, seq_data, seq_last, rec_ready, busy, done
  );

endinterface

// File: rtl/sync_ram_param.sv
// Single-port synchronous RAM with registered read address, power-up pattern
// and read-before-write behaviour for the word being written.
module sync_ram_param #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int INIT_PAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [DATA_W-1:0] data,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q
);

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  localparam logic [DATA_W-1:0] ONE_C   = DATA_W'(1'b1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  function automatic mem_t init_f();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = (INIT_PAT == 1) ? (ONE_C << (i % DATA_W)) : '0;
    end
    return m;
  endfunction

  mem_t              mem_q = init_f();
  logic [ADDR_W-1:0] addr_q;
  logic              hit_q;
  logic [DATA_W-1:0] old_q;
  logic              wr_range_s;
  logic              rd_range_s;
  logic [DATA_W-1:0] cur_s;
  logic [DATA_W-1:0] rd_s;

  assign wr_range_s = ({1'b0, addr} < DEPTH_C);
  assign rd_range_s = ({1'b0, addr_q} < DEPTH_C);

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && wr_range_s) begin
      mem_q[addr] <= data;
    end
  end

  // Registered read address plus the pre-write word for a same-address read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      hit_q  <= 1'b0;
      old_q  <= '0;
    end else begin
      addr_q <= addr;
      hit_q  <= we && wr_range_s;
      old_q  <= cur_s;
    end
  end

  always_comb begin
    cur_s = '0;
    rd_s  = '0;
    if (wr_range_s) begin
      cur_s = mem_q[addr];
    end else begin
      cur_s = '0;
    end
    if (rd_range_s) begin
      rd_s = mem_q[addr_q];
    end else begin
      rd_s = '0;
    end
  end

  assign q = hit_q ? old_q : rd_s;

endmodule

// File: rtl/seq_ram_player.sv
// RAM with built-in sequencer: random access when idle, PLAY streams len words
// out over valid/ready, RECORD stores len words arriving over valid/ready.
module seq_ram_player
  import seq_ram_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 4,
  parameter int DEPTH    = 16,
  parameter int INIT_PAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  seq_ram_player_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1'b1);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   len_q;
  logic              busy_q;
  logic              done_q;
  logic              seq_valid_q;
  logic              seq_last_q;
  logic              rec_ready_q;

  logic [ADDR_W:0]   len_eff_s;
  logic [ADDR_W-1:0] ptr_inc_s;
  logic [ADDR_W:0]   last_idx_s;
  logic              at_last_s;
  logic              next_last_s;
  logic              accept_s;
  logic              rec_wr_s;
  logic [ADDR_W-1:0] addr_mux_s;
  logic              we_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] q_s;

  assign len_eff_s   = (bus.len > DEPTH_C) ? DEPTH_C : bus.len;
  assign ptr_inc_s   = ptr_q + PTR_ONE;
  assign last_idx_s  = len_q - LEN_ONE;
  assign at_last_s   = ({1'b0, ptr_q} == last_idx_s);
  assign next_last_s = ({1'b0, ptr_inc_s} == last_idx_s);
  // abort outranks any transfer happening in the same cycle
  assign accept_s    = (state_q == ST_PLAY) && bus.seq_ready && !bus.abort;
  assign rec_wr_s    = (state_q == ST_REC) && bus.rec_valid && !bus.abort;

  // Address and write-port steering; PLAY pre-fetches ptr+1 on accept.
  always_comb begin
    addr_mux_s = ptr_q;
    we_s       = 1'b0;
    wdata_s    = bus.ram_data;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          addr_mux_s = '0;
        end else begin
          addr_mux_s = bus.ram_addr;
          we_s       = bus.ram_we;
        end
      end
      ST_PLAY: begin
        if (accept_s) begin
          addr_mux_s = ptr_inc_s;
        end else begin
          addr_mux_s = ptr_q;
        end
      end
      ST_REC: begin
        addr_mux_s = ptr_q;
        we_s       = rec_wr_s;
        wdata_s    = bus.rec_data;
      end
      default: begin
        addr_mux_s = ptr_q;
      end
    endcase
  end

  sync_ram_param #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .INIT_PAT(INIT_PAT)
  ) u_ram (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (we_s),
    .data   (wdata_s),
    .addr   (addr_mux_s),
    .q      (q_s)
  );

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      seq_valid_q <= 1'b0;
      seq_last_q  <= 1'b0;
      rec_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            ptr_q  <= '0;
            len_q  <= len_eff_s;
            busy_q <= 1'b1;
            if (len_eff_s == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (bus.op == OP_PLAY) begin
              state_q     <= ST_PLAY;
              seq_valid_q <= 1'b1;
              seq_last_q  <= (len_eff_s == LEN_ONE);
            end else begin
              state_q     <= ST_REC;
              rec_ready_q <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (bus.abort) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            seq_valid_q <= 1'b0;
            seq_last_q  <= 1'b0;
          end else if (accept_s) begin
            ptr_q <= ptr_inc_s;
            if (at_last_s) begin
              state_q     <= ST_DONE;
              seq_valid_q <= 1'b0;
              seq_last_q  <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              seq_last_q <= next_last_s;
            end
          end
        end
        ST_REC: begin
          if (bus.abort) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            rec_ready_q <= 1'b0;
          end else if (rec_wr_s) begin
            ptr_q <= ptr_inc_s;
            if (at_last_s) begin
              state_q     <= ST_DONE;
              rec_ready_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          seq_valid_q <= 1'b0;
          seq_last_q  <= 1'b0;
          rec_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q         = q_s;
  assign bus.seq_data  = q_s;
  assign bus.seq_valid = seq_valid_q;
  assign bus.seq_last  = seq_last_q;
  assign bus.rec_ready = rec_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_seq_ram_player.sv
// Directed-plus-random bench for seq_ram_player, checked against an array
// model of the RAM contents and the expected word order of each transfer.
module tb_seq_ram_player;

  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_ram_player_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  seq_ram_player #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INIT_PAT(1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int model[DEPTH];
  int pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ram_we = 1'b0; bus.ram_addr = '0; bus.ram_data = '0;
    bus.start = 1'b0; bus.op = 1'b0; bus.len = '0; bus.abort = 1'b0;
    bus.seq_ready = 1'b0; bus.rec_valid = 1'b0; bus.rec_data = '0;
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_seq_valid"}, bus.seq_valid, 0);
    chk({tag, "_seq_last"}, bus.seq_last, 0);
    chk({tag, "_rec_ready"}, bus.rec_ready, 0);
  endtask

  task automatic read_chk(input int a, input string tag);
    bus.ram_addr = a[AW-1:0];
    tick();
    chk(tag, bus.q, model[a]);
  endtask

  // Random-access write, then confirm old data on the next cycle and new after.
  task automatic write_rw(input int a, input int d);
    bus.ram_addr = a[AW-1:0]; bus.ram_data = d[DW-1:0]; bus.ram_we = 1'b1;
    tick();
    bus.ram_we = 1'b0;
    chk("rbw_old", bus.q, model[a]);
    model[a] = d % 16;
    tick();
    chk("rbw_new", bus.q, model[a]);
  endtask

  task automatic finish_chk(input string tag);
    chk({tag, "_done_pulse"}, bus.done, 1);
    chk({tag, "_busy_in_done"}, bus.busy, 1);
    chk({tag, "_valid_off"}, bus.seq_valid, 0);
    chk({tag, "_ready_off"}, bus.rec_ready, 0);
    tick();
    chk({tag, "_done_fall"}, bus.done, 0);
    chk({tag, "_busy_fall"}, bus.busy, 0);
  endtask

  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random.
  task automatic play(input int lreq, input int mode, input bit inject, input int abort_at);
    int L = (lreq > DEPTH) ? DEPTH : lreq;
    int idx = 0;
    int c = 0;
    bit rdy;
    bus.start = 1'b1; bus.op = 1'b0; bus.len = lreq[AW:0];
    tick();
    bus.start = 1'b0;
    if (L == 0) begin
      chk("play0_valid", bus.seq_valid, 0);
      finish_chk("play0");
      return;
    end
    while (idx < L && c < 200) begin
      chk("play_valid", bus.seq_valid, 1);
      chk("play_busy", bus.busy, 1);
      chk("play_done_low", bus.done, 0);
      chk("play_data", bus.seq_data, model[idx]);
      chk("play_q", bus.q, model[idx]);
      chk("play_last", bus.seq_last, (idx == L - 1) ? 1 : 0);
      if (c == abort_at) begin
        bus.abort = 1'b1; bus.seq_ready = 1'b1;
        tick();
        bus.abort = 1'b0; bus.seq_ready = 1'b0;
        check_idle_outs("play_abort");
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((c % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.seq_ready = rdy;
      bus.start = inject && (c == 1); bus.op = 1'b1; bus.len = 5'd2;
      bus.ram_we = inject && (c == 2);
      bus.ram_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.ram_data = DW'($urandom_range(0, 15));
      tick();
      bus.start = 1'b0; bus.ram_we = 1'b0; bus.seq_ready = 1'b0;
      if (rdy) idx++;
      c++;
    end
    if (idx < L) begin
      chk("play_timeout", idx, L);
      return;
    end
    finish_chk("play");
  endtask

  task automatic record(input int lreq, input bit gap, input int abort_after);
    int L = (lreq > DEPTH) ? DEPTH : lreq;
    int n = 0;
    int c = 0;
    int d;
    bit v;
    bus.start = 1'b1; bus.op = 1'b1; bus.len = lreq[AW:0];
    tick();
    bus.start = 1'b0;
    if (L == 0) begin
      finish_chk("rec0");
      return;
    end
    while (n < L && c < 200) begin
      chk("rec_ready", bus.rec_ready, 1);
      chk("rec_busy", bus.busy, 1);
      chk("rec_done_low", bus.done, 0);
      if (n == abort_after) begin
        bus.abort = 1'b1; bus.rec_valid = 1'b1; bus.rec_data = DW'($urandom_range(0, 15));
        tick();
        bus.abort = 1'b0; bus.rec_valid = 1'b0;
        check_idle_outs("rec_abort");
        return;
      end
      v = gap ? ($urandom_range(0, 2) != 0) : 1'b1;
      d = (pend.size() > 0) ? pend[0] : int'($urandom_range(0, 15));
      bus.rec_valid = v; bus.rec_data = d[DW-1:0];
      tick();
      bus.rec_valid = 1'b0;
      if (v) begin
        model[n] = d;
        if (pend.size() > 0) void'(pend.pop_front());
        n++;
      end
      c++;
    end
    if (n < L) begin
      chk("rec_timeout", n, L);
      return;
    end
    finish_chk("rec");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = 1 << (i % DW);
    idle_inputs();
    #2;
    check_idle_outs("reset");
    chk("reset_q", bus.q, model[0]);
    #10;
    reset_n = 1'b1;
    tick();

    // power-up pattern through random reads
    for (int i = 0; i < 16; i++) read_chk(int'($urandom_range(0, DEPTH - 1)), "pwr_read");

    play(5, 0, 1'b0, -1);
    play(4, 1, 1'b0, -1);

    pend = '{10, 5, 3};
    record(3, 1'b1, -1);
    play(3, 0, 1'b0, -1);
    read_chk(3, "ram3_model");
    chk("ram3_is_8", bus.q, 8);

    play(0, 0, 1'b0, -1);
    record(0, 1'b0, -1);
    for (int i = 0; i < 4; i++) read_chk(i, "len0_unchanged");
    play(20, 2, 1'b1, -1);
    play(20, 0, 1'b0, -1);

    record(8, 1'b1, 2);
    play(3, 2, 1'b0, -1);
    play(6, 2, 1'b0, 3);

    for (int i = 0; i < 4; i++)
      write_rw(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) begin
      record(int'($urandom_range(1, 18)), 1'b1, -1);
      play(int'($urandom_range(1, 18)), 2, 1'b1, -1);
    end

    // reset in the middle of PLAY
    bus.start = 1'b1; bus.op = 1'b0; bus.len = 5'd8;
    tick();
    bus.start = 1'b0; bus.seq_ready = 1'b1;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outs("midreset");
    chk("midreset_q", bus.q, model[0]);
    bus.seq_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) read_chk(i, "retained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
